uart_tx_serializer: RTL

- Consumer stage directly downstream of the TX-path fifo_v3 instance (FALL_THROUGH=0, DATA_WIDTH=8) in the AXI-to-UART bridge.
- Pops bytes from the FIFO and serialises each one onto the UART TX line as a frame: start bit, 8 data bits sent LSB first, optional parity bit, then 1 or 2 stop bits.
- Bit timing comes from a programmable clock divider.
- Configuration comes from the bridge register block.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_gen.sv | 41 ++++
 rtl/uart_tx_serializer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
// Purpose: state encoding, latched per-frame configuration and line idle level
//          shared by the UART TX serializer and its baud generator.
package uart_pkg;

    localparam int   UART_DIV_WIDTH  = 16;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

    // clk_div holds the effective (never zero) bit period.
    typedef struct packed {
        logic [UART_DIV_WIDTH-1:0] clk_div;
        logic                      parity_en;
        logic                      parity_odd;
        logic                      stop2;
    } uart_cfg_t;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - per-bit cycle counter producing a bit_done strobe
// Purpose: counts 0..div_i-1 while enabled; bit_done_o marks the last cycle
//          of each bit period and the counter wraps to 0 on it.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   enable_i       count only while a frame is active
//   restart_i      force the counter to 0 (start of a new character)
//   div_i          cycles per bit, must be non-zero
//   bit_done_o     high in the final cycle of a bit period
module uart_baud_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 restart_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 bit_done_o
);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 w_last;

    assign w_last     = (r_cnt == (div_i - DIV_WIDTH'(1)));
    assign bit_done_o = enable_i & w_last;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (restart_i) begin
            r_cnt <= '0;
        end else if (enable_i) begin
            if (w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DIV_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - pops bytes from the TX FIFO and serialises UART frames
// Purpose: frame = start bit, DATA_WIDTH data bits LSB first, optional parity,
//          1 or 2 stop bits; bit period from a programmable divider.
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   cfg_clk_div_i        cycles per bit (0 behaves as 1)
//   cfg_parity_en_i      insert parity bit
//   cfg_parity_odd_i     1 = odd parity, 0 = even
//   cfg_stop2_i          1 = two stop bits
//   fifo_empty_i         TX FIFO empty flag
//   fifo_data_i          TX FIFO head, valid when not empty
//   fifo_pop_o           one-cycle pop per character (combinational)
//   tx_o                 serial line, idles high (registered)
//   busy_o               frame in progress (registered)
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DIV_WIDTH-1:0]  cfg_clk_div_i,
    input  logic                  cfg_parity_en_i,
    input  logic                  cfg_parity_odd_i,
    input  logic                  cfg_stop2_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_pop_o,
    output logic                  tx_o,
    output logic                  busy_o
);

    localparam int IDX_WIDTH = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DATA_WIDTH - 1);

    uart_tx_state_e        r_state;
    uart_tx_state_e        w_state_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [IDX_WIDTH-1:0]  r_idx;
    logic [IDX_WIDTH-1:0]  w_idx_next;
    // Even parity of the character; the odd flag is applied when the bit is sent.
    logic                  r_parity;
    logic                  w_parity_next;
    uart_cfg_t             r_cfg;
    logic                  r_tx;
    logic                  w_tx_next;
    logic                  r_busy;
    logic                  w_pop;
    logic                  w_bit_done;
    logic [DIV_WIDTH-1:0]  w_div_eff;

    assign w_div_eff = (cfg_clk_div_i == '0) ? DIV_WIDTH'(1) : cfg_clk_div_i;

    uart_baud_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_gen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .enable_i   (r_state != IDLE),
        .restart_i  (w_pop),
        .div_i      (DIV_WIDTH'(r_cfg.clk_div)),
        .bit_done_o (w_bit_done)
    );

    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_idx_next    = r_idx;
        w_parity_next = r_parity;
        w_pop         = 1'b0;

        case (r_state)
            IDLE: begin
                if (!fifo_empty_i) begin
                    w_pop        = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_bit_done) begin
                    w_state_next = DATA;
                    w_idx_next   = '0;
                end
            end
            DATA: begin
                if (w_bit_done) begin
                    w_shift_next = r_shift >> 1;
                    if (r_idx == LAST_IDX) begin
                        w_idx_next   = '0;
                        w_state_next = r_cfg.parity_en ? PARITY : STOP;
                    end else begin
                        w_idx_next = r_idx + IDX_WIDTH'(1);
                    end
                end
            end
            PARITY: begin
                if (w_bit_done) begin
                    w_state_next = STOP;
                    w_idx_next   = '0;
                end
            end
            STOP: begin
                if (w_bit_done) begin
                    // r_idx counts completed stop bits; the last one ends the frame.
                    if (r_idx == IDX_WIDTH'(r_cfg.stop2)) begin
                        w_idx_next = '0;
                        if (!fifo_empty_i) begin
                            w_pop        = 1'b1;
                            w_state_next = START;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_idx_next = r_idx + IDX_WIDTH'(1);
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // The state register is already IDLE during reset; keep the pop quiet too.
        if (rst_i) begin
            w_pop = 1'b0;
        end

        if (w_pop) begin
            w_shift_next  = fifo_data_i;
            w_parity_next = ^fifo_data_i;
            w_idx_next    = '0;
        end

        // tx_o is registered, so decode the line level of the state being entered.
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            PARITY:  w_tx_next = r_parity ^ r_cfg.parity_odd;
            default: w_tx_next = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_idx    <= '0;
            r_parity <= 1'b0;
            r_cfg    <= '0;
            r_tx     <= UART_IDLE_LEVEL;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_shift  <= w_shift_next;
            r_idx    <= w_idx_next;
            r_parity <= w_parity_next;
            r_tx     <= w_tx_next;
            r_busy   <= (w_state_next != IDLE);
            if (w_pop) begin
                r_cfg.clk_div    <= UART_DIV_WIDTH'(w_div_eff);
                r_cfg.parity_en  <= cfg_parity_en_i;
                r_cfg.parity_odd <= cfg_parity_odd_i;
                r_cfg.stop2      <= cfg_stop2_i;
            end
        end
    end

    assign fifo_pop_o = w_pop;
    assign tx_o       = r_tx;
    assign busy_o     = r_busy;

endmodule
